branch_predictor_btb: RTL
=========================

# branch_predictor_btb

Fetch-side branch predictor that guesses the next PC, complementing the execute-stage branch unit, which computes the actual next PC. A direct-mapped table combines a branch target buffer with 2-bit saturating direction counters. The table is looked up with the fetch PC and returns a registered prediction one cycle later. It is trained by the resolved outcome of each conditional branch coming back from execute (taken flag, `PC + branch_offset` target).

## Interface
- `ADDR_W`, default 40: PC/target width in bits.
- `IDX_W`, default 4: log2 of the entry count; 16 entries by default.
- `TAG_W`, default 8: tag width, taken from `PC[IDX_W+2+TAG_W-1 : IDX_W+2]`.
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  reset; asynchronous and active-high.
- `Stall`  in  1  freezes the prediction stage (lookup ignored, outputs held).
- `Lookup_valid`  in  1  fetch presents `Lookup_PC` this cycle.
- `Lookup_PC`  in  ADDR_W  fetch PC.
- `Pred_valid`  out  1  prediction outputs are valid (registered).
- `Pred_taken`  out  1  predicted taken.
- `Pred_target`  out  ADDR_W  predicted next PC.
- `Upd_valid`  in  1  one resolved conditional branch this cycle.
- `Upd_PC`  in  ADDR_W  PC of the resolved branch.
- `Upd_taken`  in  1  actual direction.
- `Upd_target`  in  ADDR_W  computed target (`PC + offset`), used only when taken.

## Operation
- Index is `PC[IDX_W+1:2]`. `PC[1:0]` is ignored for both index and tag.
- Each entry holds: valid bit, tag, target, and a 2-bit counter.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Hit: the entry is valid and its stored tag equals the PC tag.
- Lookup, when `Lookup_valid && !Stall`:
  - On a hit with counter[1]=1: predict taken, target = stored target.
  - Otherwise: predict not-taken, target = `Lookup_PC + 4`, truncated modulo 2^ADDR_W.
- Update, when `Upd_valid`:
  - Hit and taken: counter increments, saturating at 11. Stored target is overwritten with `Upd_target`.
  - Hit and not-taken: counter decrements, saturating at 00. Tag and target are unchanged.
  - Miss and taken: allocate the entry (replacing any prior occupant). Set valid=1, tag, target=`Upd_target`, counter=10.
  - Miss and not-taken: no state change.
- Updates are applied regardless of `Stall`. There is at most one update per cycle.
- There are no other state machines. The only sequential state is the table plus the output registers.

## Timing
- Lookup latency is 1 cycle. Inputs sampled at edge N give `Pred_*` valid after edge N.
- Lookup reads table state before the same-edge update. A simultaneous update to the same index is not forwarded and becomes visible from the next lookup onward.
- `Pred_valid` follows the sampled `Lookup_valid` when `!Stall`.
- While `Stall`=1, all `Pred_*` hold their values, including `Pred_valid`.
- When `Pred_valid`=0, `Pred_taken` and `Pred_target` still update from the lookup but must be ignored.
- Update latency is 1 cycle: a lookup sampled at the edge after the update sees the new state.
- Reset, asserted asynchronously at any time including mid-update:
  - All valid bits are cleared and all counters set to 01.
  - Tags and targets are also cleared to 0.
  - Outputs go to `Pred_valid`=0, `Pred_taken`=0, `Pred_target`=0 immediately.
  - An update in flight on the reset edge is discarded.
- After reset deasserts, the first lookup is on the next rising edge.

## Test plan
- **Post-reset miss:** after reset, lookup PC=0x1000 → next cycle `Pred_valid`=1, `Pred_taken`=0, `Pred_target`=0x1004.
- **Allocate then hit:** update PC=0x1000, taken, target=0x0F00 → lookup 0x1000 gives taken/0x0F00. Then one not-taken update (counter 10→01) → lookup gives not-taken/0x1004.
- **Saturation:** from allocation, 3 taken updates → counter 11. Then 1 not-taken update → still predicts taken. A 2nd not-taken update → not-taken. Then 5 more not-taken updates → counter held at 00, and the next taken update gives 01, still predicting not-taken.
- **Alias and tag:** allocate 0x1000. Lookup 0x2000 (same index, different tag) → miss, target 0x2004. A not-taken update to 0x2000 does not disturb 0x1000. A taken update to 0x2000 with target 0x3000 evicts it, so lookup 0x1000 then misses.
- **Same-cycle update/lookup, same index:** the lookup returns pre-update data, and the following lookup returns post-update data.
- **Stall, wrap, and reset:**
  - Stall held 3 cycles → outputs unchanged while an update during the stall still takes effect.
  - Lookup PC=0xFF_FFFF_FFFC → target wraps to 0x0.
  - RST pulsed mid-update → outputs are 0 asynchronously and the table is empty afterward.

Source files
------------

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Registered one-cycle lookup; trained by resolved conditional branches from execute.
module branch_predictor_btb #(
  parameter int ADDR_W = 40,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Stall,
  input  logic              Lookup_valid,
  input  logic [ADDR_W-1:0] Lookup_PC,
  output logic              Pred_valid,
  output logic              Pred_taken,
  output logic [ADDR_W-1:0] Pred_target,
  input  logic              Upd_valid,
  input  logic [ADDR_W-1:0] Upd_PC,
  input  logic              Upd_taken,
  input  logic [ADDR_W-1:0] Upd_target
);
  localparam int NENT = 1 << IDX_W;
  localparam int TLO  = IDX_W + 2;

  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] tgt;
    logic [1:0]        ctr;
  } entry_t;

  entry_t tbl_q [NENT];

  logic              pv_q, pt_q;
  logic [ADDR_W-1:0] ptg_q;

  // Lookup path reads the table as it stood before this edge's update.
  logic [IDX_W-1:0]  l_idx;
  logic [TAG_W-1:0]  l_tag;
  entry_t            l_ent;
  logic              l_taken;
  logic [ADDR_W-1:0] l_tgt;

  assign l_idx   = Lookup_PC[IDX_W+1:2];
  assign l_tag   = Lookup_PC[TLO+TAG_W-1:TLO];
  assign l_ent   = tbl_q[l_idx];
  assign l_taken = l_ent.vld && (l_ent.tag == l_tag) && l_ent.ctr[1];
  assign l_tgt   = l_taken ? l_ent.tgt : Lookup_PC + ADDR_W'(4);

  // Update path
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  entry_t           u_ent;
  logic             u_hit;
  logic             u_we;
  entry_t           u_ent_d;
  logic             unused_ok;

  assign u_idx     = Upd_PC[IDX_W+1:2];
  assign u_tag     = Upd_PC[TLO+TAG_W-1:TLO];
  assign u_ent     = tbl_q[u_idx];
  assign u_hit     = u_ent.vld && (u_ent.tag == u_tag);
  assign unused_ok = ^Upd_PC;

  always_comb begin
    u_ent_d = u_ent;
    u_we    = 1'b0;
    if (Upd_valid) begin
      if (u_hit) begin
        u_we = 1'b1;
        if (Upd_taken) begin
          u_ent_d.tgt = Upd_target;
          if (u_ent.ctr != 2'b11) u_ent_d.ctr = u_ent.ctr + 2'd1;
        end else if (u_ent.ctr != 2'b00) begin
          u_ent_d.ctr = u_ent.ctr - 2'd1;
        end
      end else if (Upd_taken) begin
        // Allocation evicts whatever lived at this index.
        u_we    = 1'b1;
        u_ent_d = '{vld: 1'b1, tag: u_tag, tgt: Upd_target, ctr: 2'b10};
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NENT; i++)
        tbl_q[i] <= '{vld: 1'b0, tag: '0, tgt: '0, ctr: 2'b01};
    end else if (u_we) begin
      tbl_q[u_idx] <= u_ent_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pv_q  <= 1'b0;
      pt_q  <= 1'b0;
      ptg_q <= '0;
    end else if (!Stall) begin
      pv_q  <= Lookup_valid;
      pt_q  <= l_taken;
      ptg_q <= l_tgt;
    end
  end

  assign Pred_valid  = pv_q;
  assign Pred_taken  = pt_q;
  assign Pred_target = ptg_q;

endmodule
